// File: rtl/pcie_vc_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pcie_vc_arbiter
// Brief    : Round-robin scheduler sharing one output datapath among four
//            virtual-channel FWFT FIFOs, with almost-full throttling, a
//            reset/init/idle/active/error state machine and sticky overflow.
//            Optional feature macro: PCIE_ARB_PRIORITY_EN (VC0 strict
//            priority, VCs 1-3 round-robin among themselves).
// Revision : 1.0 - initial release
// ============================================================================
module pcie_vc_arbiter #(
  parameter int DATA_W         = 8,
  parameter int DOWN_DEPTH     = 16,
  parameter int UMBRAL_DEFAULT = 12
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  INIT,
  input  logic [4:0]            umbral_in,
  input  logic [3:0]            fifo_empty,
  input  logic [4*DATA_W-1:0]   fifo_data,
  input  logic [4:0]            down_count,
  output logic [3:0]            fifo_pop,
  output logic [DATA_W-1:0]     DATA,
  output logic                  VALID_OUT,
  output logic [2:0]            state,
  output logic                  idle,
  output logic                  error
);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  localparam logic [4:0] C_UMBRAL_RST = 5'(UMBRAL_DEFAULT);
  localparam logic [4:0] C_DEPTH_FULL = 5'(DOWN_DEPTH);

  state_t              state_q, state_d;
  logic [4:0]          umbral_q, umbral_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                idle_q, idle_d;
  logic                error_q, error_d;

  logic                overflow;
  logic                allow;
  logic                cand_vld;
  logic [1:0]          cand_idx;
  logic                grant;
  logic [DATA_W-1:0]   gnt_word;

  // A word delivered while the downstream FIFO is already full is lost;
  // the datapath is frozen in that cycle so nothing further is popped.
  assign overflow = valid_q && (down_count == C_DEPTH_FULL);
  assign allow    = (state_q == ST_ACTIVE) && (down_count < umbral_q) && !overflow;
  assign grant    = allow && cand_vld;

  // Candidate search: first non-empty VC starting at the round-robin pointer
  always_comb begin
    cand_vld = 1'b0;
    cand_idx = ptr_q;
`ifdef PCIE_ARB_PRIORITY_EN
    if (!fifo_empty[0]) begin
      cand_vld = 1'b1;
      cand_idx = 2'd0;
    end
`endif
    for (int k = 0; k < 4; k++) begin
      if (!cand_vld && !fifo_empty[ptr_q + 2'(k)]) begin
        cand_vld = 1'b1;
        cand_idx = ptr_q + 2'(k);
      end
    end
  end

  // Head-word mux and one-hot pop strobe for the granted VC
  always_comb begin
    gnt_word = '0;
    fifo_pop = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (cand_idx == 2'(i)) begin
        gnt_word = fifo_data[i*DATA_W +: DATA_W];
      end
    end
    if (grant) begin
      fifo_pop[cand_idx] = 1'b1;
    end
  end

  // Next-state, threshold, pointer and output-register computation
  always_comb begin
    state_d  = state_q;
    umbral_d = umbral_q;
    ptr_d    = ptr_q;
    data_d   = data_q;
    valid_d  = grant;

    if (grant) begin
      data_d = gnt_word;
`ifdef PCIE_ARB_PRIORITY_EN
      if (cand_idx != 2'd0) begin
        ptr_d = cand_idx + 2'd1;
      end
`else
      ptr_d = cand_idx + 2'd1;
`endif
    end

    case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT: begin
        umbral_d = umbral_in;
        if (!INIT) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (INIT)                     state_d = ST_INIT;
        else if (fifo_empty != 4'hF)  state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (INIT)                     state_d = ST_INIT;
        else if (fifo_empty == 4'hF)  state_d = ST_IDLE;
      end
      ST_ERROR:  state_d = ST_ERROR;
      default:   state_d = ST_RESET;
    endcase

    if (overflow && (state_q != ST_ERROR)) begin
      state_d = ST_ERROR;
    end

    idle_d  = (state_d == ST_IDLE);
    error_d = (state_d == ST_ERROR);
  end

  // State and registered outputs, cleared asynchronously by RESET
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_RESET;
      umbral_q <= C_UMBRAL_RST;
      ptr_q    <= 2'd0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      idle_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      umbral_q <= umbral_d;
      ptr_q    <= ptr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      idle_q   <= idle_d;
      error_q  <= error_d;
    end
  end

  assign DATA      = data_q;
  assign VALID_OUT = valid_q;
  assign state     = state_q;
  assign idle      = idle_q;
  assign error     = error_q;

endmodule
`default_nettype wire

// File: tb/tb_pcie_vc_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcie_vc_arbiter
// Brief    : Directed self-checking bench for pcie_vc_arbiter. VC FIFOs are
//            modelled as word counters with a fixed head word 8'hA0+n.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcie_vc_arbiter;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        INIT = 1'b0;
  logic [4:0]  umbral_in = 5'd10;
  logic [3:0]  fifo_empty = 4'hF;
  logic [31:0] fifo_data = 32'hA3A2A1A0;
  logic [4:0]  down_count = 5'd0;
  logic [3:0]  fifo_pop;
  logic [7:0]  DATA;
  logic        VALID_OUT;
  logic [2:0]  state;
  logic        idle;
  logic        error;

  int checks = 0;
  int errors = 0;
  int cnt [4];
  logic [7:0] exp_fair [8];

  pcie_vc_arbiter dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .INIT       (INIT),
    .umbral_in  (umbral_in),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .down_count (down_count),
    .fifo_pop   (fifo_pop),
    .DATA       (DATA),
    .VALID_OUT  (VALID_OUT),
    .state      (state),
    .idle       (idle),
    .error      (error)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < 4; i++) fifo_empty[i] = (cnt[i] == 0);
  endtask

  // Advance one clock; the FIFO model honours the pop strobe seen before the edge
  task automatic tick();
    logic [3:0] p;
    #1;
    p = fifo_pop;
    @(posedge CLK);
    #1;
    for (int i = 0; i < 4; i++) if (p[i] && cnt[i] > 0) cnt[i]--;
    refresh();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) cnt[i] = 0;
`ifdef PCIE_ARB_PRIORITY_EN
    exp_fair = '{8'hA0, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA1, 8'hA2, 8'hA3};
`else
    exp_fair = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0, 8'hA1, 8'hA2, 8'hA3};
`endif

    // ---------------- reset state ----------------
    tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_valid", 32'(VALID_OUT), 32'd0);
    chk("rst_data", 32'(DATA), 32'd0);
    chk("rst_pop", 32'(fifo_pop), 32'd0);
    chk("rst_idle", 32'(idle), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_umbral", 32'(dut.umbral_q), 32'd12);

    // ---------------- init sequence ----------------
    RESET = 1'b0; INIT = 1'b1; umbral_in = 5'd10;
    tick();
    chk("init_state_a", 32'(state), 32'd1);
    tick();
    chk("init_state_b", 32'(state), 32'd1);
    chk("init_pop", 32'(fifo_pop), 32'd0);
    INIT = 1'b0;
    tick();
    chk("idle_state", 32'(state), 32'd2);
    chk("idle_flag", 32'(idle), 32'd1);
    chk("idle_valid", 32'(VALID_OUT), 32'd0);
    chk("idle_umbral", 32'(dut.umbral_q), 32'd10);

    // ---------------- fairness ----------------
    for (int i = 0; i < 4; i++) cnt[i] = 2;
    refresh();
    #1;
    chk("idle_no_pop", 32'(fifo_pop), 32'd0);
    tick();
    chk("fair_active", 32'(state), 32'd3);
    chk("fair_idle_low", 32'(idle), 32'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("fair_data", 32'(DATA), 32'(exp_fair[k]));
      chk("fair_valid", 32'(VALID_OUT), 32'd1);
    end
    tick();
    chk("fair_end_state", 32'(state), 32'd2);
    chk("fair_end_valid", 32'(VALID_OUT), 32'd0);

    // ---------------- skip empties ----------------
    cnt[1] = 2; cnt[3] = 2;
    refresh();
    tick();
    chk("skip_active", 32'(state), 32'd3);
    #1;
    chk("skip_pop_vc1", 32'(fifo_pop), 32'h2);
    tick();
    chk("skip_d0", 32'(DATA), 32'hA1);
    chk("skip_pop_vc3", 32'(fifo_pop), 32'h8);
    tick();
    chk("skip_d1", 32'(DATA), 32'hA3);
    chk("skip_v1", 32'(VALID_OUT), 32'd1);
    tick();
    chk("skip_d2", 32'(DATA), 32'hA1);
    chk("skip_v2", 32'(VALID_OUT), 32'd1);
    tick();
    chk("skip_d3", 32'(DATA), 32'hA3);
    tick();
    chk("skip_end_state", 32'(state), 32'd2);

    // ---------------- throttle ----------------
    INIT = 1'b1; umbral_in = 5'd4;
    tick();
    chk("thr_init", 32'(state), 32'd1);
    INIT = 1'b0;
    tick();
    chk("thr_umbral", 32'(dut.umbral_q), 32'd4);
    cnt[2] = 10; down_count = 5'd3;
    refresh();
    tick();
    #1;
    chk("thr_pop_3", 32'(fifo_pop), 32'h4);
    tick();
    chk("thr_data", 32'(DATA), 32'hA2);
    chk("thr_valid", 32'(VALID_OUT), 32'd1);
    down_count = 5'd4;
    #1;
    chk("thr_pop_4", 32'(fifo_pop), 32'd0);
    tick();
    chk("thr_valid_off", 32'(VALID_OUT), 32'd0);
    chk("thr_data_hold", 32'(DATA), 32'hA2);
    down_count = 5'd3;
    #1;
    chk("thr_pop_resume", 32'(fifo_pop), 32'h4);
    tick();
    chk("thr_valid_resume", 32'(VALID_OUT), 32'd1);
    down_count = 5'd0;
    cnt[2] = 0;
    refresh();
    tick();
    chk("thr_end_state", 32'(state), 32'd2);

    // ---------------- reset mid-stream ----------------
    for (int i = 0; i < 4; i++) cnt[i] = 3;
    refresh();
    tick();
    tick();
`ifdef PCIE_ARB_PRIORITY_EN
    chk("mid_d0", 32'(DATA), 32'hA0);
`else
    chk("mid_d0", 32'(DATA), 32'hA3);
`endif
    tick();
    chk("mid_d1", 32'(DATA), 32'hA0);
    chk("mid_valid", 32'(VALID_OUT), 32'd1);
    RESET = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(VALID_OUT), 32'd0);
    chk("mid_rst_data", 32'(DATA), 32'd0);
    chk("mid_rst_pop", 32'(fifo_pop), 32'd0);
    chk("mid_rst_state", 32'(state), 32'd0);
    @(posedge CLK);
    #1;
    RESET = 1'b0; INIT = 1'b1; umbral_in = 5'd17;
    tick();
    INIT = 1'b0;
    tick();
    chk("mid_idle", 32'(state), 32'd2);
    tick();
    chk("mid_active", 32'(state), 32'd3);
    #1;
    chk("mid_ptr_vc0", 32'(fifo_pop), 32'h1);

    // ---------------- overflow ----------------
    tick();
    chk("ovf_valid", 32'(VALID_OUT), 32'd1);
    down_count = 5'd16;
    tick();
    chk("ovf_state", 32'(state), 32'd4);
    chk("ovf_error", 32'(error), 32'd1);
    chk("ovf_valid_off", 32'(VALID_OUT), 32'd0);
    chk("ovf_pop", 32'(fifo_pop), 32'd0);
    down_count = 5'd0;
    INIT = 1'b1;
    tick();
    tick();
    INIT = 1'b0;
    tick();
    chk("ovf_init_ign", 32'(state), 32'd4);
    chk("ovf_sticky", 32'(error), 32'd1);
    chk("ovf_pop_hold", 32'(fifo_pop), 32'd0);
    RESET = 1'b1;
    #1;
    chk("ovf_rst_state", 32'(state), 32'd0);
    chk("ovf_rst_error", 32'(error), 32'd0);
    RESET = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard bound so the run always ends
  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/pcie_vc_arbiter.md
# pcie_vc_arbiter

Round-robin scheduler that shares the single 8-bit PCIe output datapath among four virtual-channel (VC) FIFOs. It sits between the per-VC first-word-fall-through FIFOs and the downstream output FIFO. It pops one word per cycle from the selected VC and drives `DATA`/`VALID_OUT`. It throttles on a programmable almost-full threshold and sequences reset, init, idle, active and error through a state machine.

## Interface
- `DATA_W`, 8, word width per VC and on `DATA`.
- `DOWN_DEPTH`, 16, downstream FIFO depth in words.
- `UMBRAL_DEFAULT`, 12, almost-full threshold loaded on reset.

Ports:
- `CLK`: input, 1 bit. Single clock, rising edge.
- `RESET`: input, 1 bit. Asynchronous, active-high.
- `INIT`: input, 1 bit. Request to (re)load the threshold.
- `umbral_in`: input, 5 bits. Threshold value, latched while in INIT.
- `fifo_empty`: input, 4 bits. Per-VC empty flag; bit i is VC i.
- `fifo_data`: input, 4*DATA_W bits. Per-VC head word; VC i is `[i*DATA_W +: DATA_W]`. Valid whenever the matching empty bit is 0.
- `down_count`: input, 5 bits. Downstream FIFO occupancy, 0..DOWN_DEPTH.
- `fifo_pop`: output, 4 bits. One-hot pop strobe to the VC FIFOs.
- `DATA`: output, DATA_W bits. Registered output word.
- `VALID_OUT`: output, 1 bit. `DATA` is valid; writes the downstream FIFO.
- `state`: output, 3 bits. Current FSM state.
- `idle`: output, 1 bit. High in IDLE.
- `error`: output, 1 bit. Sticky overflow flag.

## Operation
- State encoding: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
- While `RESET` is high:
  - state=RESET, `umbral_reg`=UMBRAL_DEFAULT, rr pointer `ptr`=0.
  - `DATA`=0, `VALID_OUT`=0, `fifo_pop`=0, `idle`=0, `error`=0.
- RESET → INIT on the first edge after `RESET` falls.
- INIT:
  - `umbral_reg` <= `umbral_in` every cycle.
  - Goes to IDLE on the first edge with `INIT`=0.
  - No pops.
- IDLE:
  - `idle`=1, no pops.
  - Goes to ACTIVE when `fifo_empty` != 4'hF.
  - Goes to INIT when `INIT`=1; INIT takes priority.
- ACTIVE, grant (combinational from registered state and inputs):
  - A grant is allowed only when `down_count` < `umbral_reg`.
  - Grant goes to the first non-empty VC, searching `ptr`, `ptr+1`, ... mod 4.
  - `fifo_pop` is that VC's one-hot bit; otherwise 0.
- ACTIVE, on a granted edge:
  - `DATA` <= head word of the granted VC.
  - `VALID_OUT` <= 1.
  - `ptr` <= grant+1 mod 4.
- ACTIVE, on an edge with no grant: `VALID_OUT` <= 0 and `DATA` holds.
- ACTIVE exits:
  - To IDLE when `fifo_empty`=4'hF. The last word's `VALID_OUT` still appears that edge.
  - To INIT when `INIT`=1.
- Overflow: if `VALID_OUT`=1 and `down_count`=DOWN_DEPTH on the same edge, go to ERROR.
- ERROR:
  - `error`=1, no pops, `VALID_OUT`=0.
  - Held until `RESET`; `INIT` is ignored.
- `umbral_reg`=0 blocks every grant, which is legal. Values > DOWN_DEPTH never throttle.

## Timing
- Pop-to-output latency: 1 cycle. The pop strobe in cycle N gives `DATA`/`VALID_OUT` after edge N.
- Sustained throughput: 1 word/cycle while below threshold and any VC is non-empty.
- Throttle reacts in the same cycle that `down_count` reaches `umbral_reg`. At most one word is already in flight, so the threshold must be ≤ DOWN_DEPTH−1 to avoid ERROR.
- Reset mid-transfer clears all outputs immediately (asynchronous). The in-flight word is dropped.

## Configuration
- `PCIE_ARB_PRIORITY_EN` defined:
  - VC0 has strict priority: whenever `fifo_empty[0]`=0 and throttle allows, VC0 is granted.
  - `ptr` is not updated by VC0 grants; VCs 1–3 round-robin among themselves.
- Undefined: pure 4-way round-robin as described above.

## Test plan
- Reset and init sequence:
  - Stimulus: assert `RESET`, release; hold `INIT`=1 with `umbral_in`=10 for 2 cycles, then drop it.
  - Required: `state` goes 0→1→2, outputs all 0, `idle`=1, `umbral_reg`=10.
- Fairness:
  - Stimulus: all four VCs hold 2 words (VCn = 8'hA0+n), `down_count`=0.
  - Required: `DATA` = A0,A1,A2,A3,A0,A1,A2,A3 on consecutive cycles with `VALID_OUT`=1, then IDLE.
  - With `PCIE_ARB_PRIORITY_EN`: A0,A0,A1,A2,A3,A1,A2,A3.
- Throttle:
  - Stimulus: `umbral_reg`=4, VC2 non-empty, `down_count` rises 3→4.
  - Required: `fifo_pop` is 0 in the cycle `down_count`=4, and `VALID_OUT`=0 after the next edge.
  - `down_count` back to 3: pops resume the same cycle.
- Overflow:
  - Stimulus: `umbral_in`=17, `down_count`=16 while `VALID_OUT`=1.
  - Required: `state`=4, `error`=1, `fifo_pop`=0; `INIT` pulses have no effect; `RESET` clears.
- Reset mid-stream:
  - Stimulus: assert `RESET` during ACTIVE with `VALID_OUT`=1.
  - Required: `VALID_OUT`, `DATA` and `fifo_pop` go to 0 before the next edge; `ptr` restarts at VC0.
- Skip empties:
  - Stimulus: only VC1 and VC3 non-empty, `ptr`=0.
  - Required: grants alternate VC1, VC3, VC1 with no idle cycles.
